// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck CPU I/O block.
//   BF_DATA_WIDTH  : default byte width, matches the CPU data path
//   BF_FIFO_AW     : default log2 FIFO depth
//   STAT_*_BIT     : bit positions in the future memory-mapped status word
package bf_pkg;
  localparam int BF_DATA_WIDTH = 8;
  localparam int BF_FIFO_AW    = 4;

  // status register layout
  localparam int STAT_OVERFLOW_BIT = 0;
  localparam int STAT_W            = 1;
endpackage

// File: rtl/bf_io_controller_byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, async active-low reset (pointers/count cleared)
//   push, din  : write din when push & !full
//   pop        : advance head when pop & !empty
//   head       : current head word, 0 while empty (no read latency)
//   count      : registered occupancy 0..2**AW
//   full/empty : decoded from the registered count only
module byte_fifo
  import bf_pkg::*;
#(
  parameter int DATA_WIDTH = BF_DATA_WIDTH,
  parameter int AW         = BF_FIFO_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << AW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // Guard here too so a careless caller can never corrupt pointers.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage needs no reset; the empty mask below hides stale words.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/bf_io_controller.sv
// bf_io_controller: byte-stream glue between the Brainfuck CPU and a host link.
//   host_in_*   : host->CPU bytes, valid/ready, buffered in the input FIFO
//   cpu_data_*  : CPU data_in/data_available/data_read and data_out/data_out_en
//   host_out_*  : CPU->host bytes, valid/ready, drained from the output FIFO
//   clear_overflow : pulse clearing the sticky overflow flag
//   in_count/out_count : FIFO occupancies
//   overflow    : sticky, an output byte arrived while the output FIFO was full
// The CPU has no output stall, so a write into a full output FIFO is dropped
// and flagged rather than back-pressured.
module bf_io_controller
  import bf_pkg::*;
#(
  parameter int DATA_WIDTH = BF_DATA_WIDTH,
  parameter int FIFO_AW    = BF_FIFO_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] host_in_data,
  input  logic                  host_in_valid,
  output logic                  host_in_ready,
  output logic [DATA_WIDTH-1:0] host_out_data,
  output logic                  host_out_valid,
  input  logic                  host_out_ready,
  output logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic                  cpu_data_avail,
  input  logic                  cpu_data_read,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  input  logic                  cpu_data_out_en,
  input  logic                  clear_overflow,
  output logic [FIFO_AW:0]      in_count,
  output logic [FIFO_AW:0]      out_count,
  output logic                  overflow
);
  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push, out_pop, drop;

  // Handshakes use registered full/empty only: a same-cycle pop never
  // opens a slot for a same-cycle push when full.
  assign host_in_ready  = ~in_full;
  assign cpu_data_avail = ~in_empty;
  assign host_out_valid = ~out_empty;

  assign in_push  = host_in_valid & host_in_ready;
  assign in_pop   = cpu_data_read & cpu_data_avail;
  assign out_push = cpu_data_out_en & ~out_full;
  assign out_pop  = host_out_valid & host_out_ready;
  assign drop     = cpu_data_out_en & out_full;

  byte_fifo #(.DATA_WIDTH(DATA_WIDTH), .AW(FIFO_AW)) u_in_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_push),
    .din   (host_in_data),
    .pop   (in_pop),
    .head  (cpu_data_in),
    .count (in_count),
    .full  (in_full),
    .empty (in_empty)
  );

  byte_fifo #(.DATA_WIDTH(DATA_WIDTH), .AW(FIFO_AW)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (out_push),
    .din   (cpu_data_out),
    .pop   (out_pop),
    .head  (host_out_data),
    .count (out_count),
    .full  (out_full),
    .empty (out_empty)
  );

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end
endmodule

// File: tb/tb_bf_io_controller.sv
// Directed bench for bf_io_controller with a 4-deep FIFO configuration.
module tb_bf_io_controller;
  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] host_in_data, host_out_data, cpu_data_in, cpu_data_out;
  logic          host_in_valid, host_in_ready, host_out_valid, host_out_ready;
  logic          cpu_data_avail, cpu_data_read, cpu_data_out_en, clear_overflow;
  logic [AW:0]   in_count, out_count;
  logic          overflow;

  int checks = 0;
  int failures = 0;

  bf_io_controller #(.DATA_WIDTH(DW), .FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .cpu_data_in(cpu_data_in), .cpu_data_avail(cpu_data_avail), .cpu_data_read(cpu_data_read),
    .cpu_data_out(cpu_data_out), .cpu_data_out_en(cpu_data_out_en),
    .clear_overflow(clear_overflow), .in_count(in_count), .out_count(out_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge; outputs are then sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_count"},  32'(in_count), 0);
    chk({tag, ".out_count"}, 32'(out_count), 0);
    chk({tag, ".avail"},     32'(cpu_data_avail), 0);
    chk({tag, ".out_valid"}, 32'(host_out_valid), 0);
    chk({tag, ".in_ready"},  32'(host_in_ready), 1);
    chk({tag, ".overflow"},  32'(overflow), 0);
    chk({tag, ".cpu_din"},   32'(cpu_data_in), 0);
    chk({tag, ".out_data"},  32'(host_out_data), 0);
  endtask

  logic [DW-1:0] qin[$], qout[$];
  logic [DW-1:0] b;
  int idx;
  logic rdy;

  initial begin
    rst_n = 1'b0; host_in_data = '0; host_in_valid = 0; host_out_ready = 0;
    cpu_data_read = 0; cpu_data_out = '0; cpu_data_out_en = 0; clear_overflow = 0;
    repeat (3) step();
    chk_idle("rst");
    rst_n = 1'b1;
    step();
    chk_idle("post_rst");

    // input path: three bytes, then three reads
    for (int i = 0; i < 3; i++) begin
      host_in_valid = 1; host_in_data = 8'h41 + 8'(i);
      step();
      if (i == 0) chk("in_latency", 32'(cpu_data_avail), 1);
    end
    host_in_valid = 0;
    chk("in.head0", 32'(cpu_data_in), 32'h41);
    chk("in.avail", 32'(cpu_data_avail), 1);
    chk("in.count3", 32'(in_count), 3);
    cpu_data_read = 1;
    step(); chk("in.head1", 32'(cpu_data_in), 32'h42);
    step(); chk("in.head2", 32'(cpu_data_in), 32'h43);
    step(); chk("in.drained", 32'(cpu_data_avail), 0);
    chk("in.count0", 32'(in_count), 0);

    // empty pop is ignored
    step(); step();
    chk("epop.count", 32'(in_count), 0);
    cpu_data_read = 0;
    host_in_valid = 1; host_in_data = 8'h55;
    step();
    host_in_valid = 0;
    chk("epop.head", 32'(cpu_data_in), 32'h55);
    chk("epop.count1", 32'(in_count), 1);
    cpu_data_read = 1; step(); cpu_data_read = 0;
    chk("epop.empty", 32'(in_count), 0);

    // input full: 5 bytes offered with valid held
    idx = 0;
    host_in_valid = 1;
    for (int c = 0; c < 6; c++) begin
      host_in_data = 8'h61 + 8'(idx);
      rdy = host_in_ready;
      step();
      if (rdy) idx++;
    end
    chk("full.accepted", 32'(idx), 4);
    chk("full.count", 32'(in_count), 4);
    chk("full.ready", 32'(host_in_ready), 0);
    host_in_data = 8'h65;
    cpu_data_read = 1;
    step();  // pop only: ready was low at this edge
    cpu_data_read = 0;
    chk("full.pop_count", 32'(in_count), 3);
    chk("full.ready_back", 32'(host_in_ready), 1);
    step();  // 5th byte accepted
    host_in_valid = 0;
    chk("full.count4", 32'(in_count), 4);
    cpu_data_read = 1;
    for (int i = 0; i < 4; i++) begin
      chk("full.order", 32'(cpu_data_in), 32'h62 + i);
      step();
    end
    cpu_data_read = 0;
    chk("full.empty", 32'(cpu_data_avail), 0);

    // output overflow with host stalled
    host_out_ready = 0;
    cpu_data_out_en = 1;
    for (int i = 0; i < 5; i++) begin
      cpu_data_out = 8'h10 + 8'(i);
      step();
      if (i == 0) begin
        chk("out_latency.valid", 32'(host_out_valid), 1);
        chk("out_latency.data", 32'(host_out_data), 32'h10);
      end
      if (i == 3) chk("ovf.not_yet", 32'(overflow), 0);
    end
    chk("ovf.count", 32'(out_count), 4);
    chk("ovf.flag", 32'(overflow), 1);
    // clear together with a drop: set wins
    clear_overflow = 1; cpu_data_out = 8'h99;
    step();
    chk("ovf.set_wins", 32'(overflow), 1);
    cpu_data_out_en = 0;
    step();
    clear_overflow = 0;
    chk("ovf.cleared", 32'(overflow), 0);
    // drop while host pops that same cycle still counts as overflow
    host_out_ready = 1; cpu_data_out_en = 1; cpu_data_out = 8'hAA;
    chk("drain.head0", 32'(host_out_data), 32'h10);
    step();
    cpu_data_out_en = 0;
    chk("ovf.pop_same", 32'(overflow), 1);
    chk("drain.count3", 32'(out_count), 3);
    for (int i = 1; i < 4; i++) begin
      chk("drain.order", 32'(host_out_data), 32'h10 + i);
      step();
    end
    host_out_ready = 0;
    chk("drain.empty", 32'(host_out_valid), 0);
    chk("drain.data0", 32'(host_out_data), 0);
    clear_overflow = 1; step(); clear_overflow = 0;

    // concurrent traffic both directions
    host_in_valid = 1; cpu_data_read = 1; cpu_data_out_en = 1; host_out_ready = 1;
    for (int c = 0; c < 100; c++) begin
      b = 8'($urandom_range(0, 255));
      host_in_data = b;
      cpu_data_out = 8'($urandom_range(0, 255));
      chk("cc.in_ready", 32'(host_in_ready), 32'(qin.size() != 4));
      chk("cc.avail", 32'(cpu_data_avail), 32'(qin.size() != 0));
      chk("cc.out_valid", 32'(host_out_valid), 32'(qout.size() != 0));
      if (qin.size() != 0) begin
        chk("cc.in_data", 32'(cpu_data_in), 32'(qin[0]));
        void'(qin.pop_front());
      end
      if (qout.size() != 0) begin
        chk("cc.out_data", 32'(host_out_data), 32'(qout[0]));
        void'(qout.pop_front());
      end
      qin.push_back(b);
      qout.push_back(cpu_data_out);
      step();
      chk("cc.in_count", 32'(in_count), 1);
      chk("cc.out_count", 32'(out_count), 1);
    end
    chk("cc.overflow", 32'(overflow), 0);
    host_in_valid = 0; cpu_data_read = 0; cpu_data_out_en = 0; host_out_ready = 0;
    qin.delete(); qout.delete();

    // reset mid-run with bytes queued
    step();  // last in-flight bytes land: 1 each, now queue 2 more in
    host_in_valid = 1;
    host_in_data = 8'h71; step();
    host_in_data = 8'h72; step();
    host_in_valid = 0;
    chk("mid.in_count", 32'(in_count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    step();
    rst_n = 1'b1;
    step();
    chk_idle("mid_rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
